// File: rtl/redundant_sum_resolver_pkg.sv
// rtl/redundant_sum_resolver_pkg.sv - shared sizing, state encoding and helpers for the redundant sum resolver
package rsr_pkg;

    localparam int SIZE  = 3072;
    localparam int RADIX = 78;
    localparam int CW    = 78;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    localparam int W   = SIZE + RADIX + 2;
    localparam int NCH = ceil_div(W, CW);
    localparam int LW  = W - (NCH - 1) * CW;
    localparam int KW  = $clog2(NCH);
    localparam int PW  = NCH * CW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/redundant_sum_resolver_if.sv
// rtl/redundant_sum_resolver_if.sv - operand/result handshake bundle between producer and resolver
interface redundant_sum_resolver_if
    import rsr_pkg::*;
;
    logic         en;
    logic [W-1:0] r0;
    logic [W-1:0] r1;
    logic         ready;
    logic         busy;
    logic         done;
    logic         overrun;
    logic [W:0]   sum;

    modport master (
        output en, r0, r1,
        input  ready, busy, done, overrun, sum
    );

    modport slave (
        input  en, r0, r1,
        output ready, busy, done, overrun, sum
    );
endinterface

// File: rtl/redundant_sum_resolver_chunk_adder.sv
// rtl/redundant_sum_resolver_chunk_adder.sv - one CW-bit carry-propagate slice with carry in/out
module rsr_chunk_adder
    import rsr_pkg::*;
(
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

endmodule

// File: rtl/redundant_sum_resolver.sv
// rtl/redundant_sum_resolver.sv - folds the redundant pair r0+r1 into one binary word, CW bits per cycle
module redundant_sum_resolver
    import rsr_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    redundant_sum_resolver_if.slave  bus
);

    state_t         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   op0_q, op0_d;
    logic [W-1:0]   op1_q, op1_d;
    logic [W:0]     sum_q, sum_d;
    logic           overrun_q, overrun_d;

    logic [PW-1:0]  op0_pad, op1_pad;
    logic [CW-1:0]  ch0, ch1, ch_s;
    logic           ch_cout;
    logic [CW:0]    s_full;
    logic           accept;
    logic           last;

    // Zero-padding to a whole number of chunks keeps the short tail slice in range.
    assign op0_pad = PW'(op0_q);
    assign op1_pad = PW'(op1_q);
    assign ch0     = op0_pad[int'(k_q) * CW +: CW];
    assign ch1     = op1_pad[int'(k_q) * CW +: CW];
    assign s_full  = {ch_cout, ch_s};
    assign last    = (k_q == KW'(NCH - 1));
    assign accept  = bus.en && (state_q != RUN);

    rsr_chunk_adder u_adder (
        .a    (ch0),
        .b    (ch1),
        .cin  (carry_q),
        .s    (ch_s),
        .cout (ch_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            carry_q   <= 1'b0;
            op0_q     <= '0;
            op1_q     <= '0;
            sum_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            carry_q   <= carry_d;
            op0_q     <= op0_d;
            op1_q     <= op1_d;
            sum_q     <= sum_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = bus.en ? RUN : IDLE;
            RUN:        state_d = last ? DONE : RUN;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        op0_d     = op0_q;
        op1_d     = op1_q;
        k_d       = k_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        overrun_d = bus.en && (state_q == RUN);
        if (accept) begin
            op0_d   = bus.r0;
            op1_d   = bus.r1;
            k_d     = '0;
            carry_d = 1'b0;
        end else if (state_q == RUN) begin
            k_d     = k_q + KW'(1);
            carry_d = s_full[CW];
            // The tail chunk's carry-out lands at bit LW, which becomes sum[W].
            if (last) begin
                sum_d[W:(NCH-1)*CW] = s_full[LW:0];
            end else begin
                for (int i = 0; i < NCH - 1; i++) begin
                    if (k_q == KW'(i)) begin
                        sum_d[i*CW +: CW] = s_full[CW-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        bus.ready   = (state_q != RUN);
        bus.busy    = (state_q == RUN);
        bus.done    = (state_q == DONE);
        bus.overrun = overrun_q;
        bus.sum     = sum_q;
    end

endmodule

// File: tb/tb_redundant_sum_resolver.sv
// tb/tb_redundant_sum_resolver.sv - randomized and directed self-checking bench for redundant_sum_resolver
module tb_redundant_sum_resolver;
    import rsr_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    redundant_sum_resolver_if bus_if ();

    redundant_sum_resolver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_sum(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed top=%0h low=%0h expected top=%0h low=%0h",
                   tag, obs[W:W-32], obs[63:0], exp[W:W-32], exp[63:0]);
        end
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | W'($urandom);
        return v;
    endfunction

    function automatic logic [W:0] golden(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic wait_done(output int lat, output int bsy, output bit ovr);
        lat = 0;
        bsy = 0;
        ovr = 1'b0;
        while (!bus_if.done && lat < 200) begin
            bsy += int'(bus_if.busy);
            ovr |= bus_if.overrun;
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W:0] s, output int lat, output int bsy, output bit ovr);
        bus_if.r0 = a;
        bus_if.r1 = b;
        bus_if.en = 1'b1;
        tick();
        bus_if.en = 1'b0;
        wait_done(lat, bsy, ovr);
        s = bus_if.sum;
    endtask

    initial begin
        logic [W-1:0] a, b, a2, b2;
        logic [W:0]   s, s2, expv;
        int           lat, bsy, dcnt;
        bit           ovr;

        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus_if.en = 1'b0;
        bus_if.r0 = '0;
        bus_if.r1 = '0;
        tick();
        tick();
        chk("reset_ready", 64'(bus_if.ready), 64'(1));
        chk("reset_busy", 64'(bus_if.busy), 64'(0));
        chk("reset_done", 64'(bus_if.done), 64'(0));
        chk("reset_overrun", 64'(bus_if.overrun), 64'(0));
        chk_sum("reset_sum", bus_if.sum, '0);
        rst_n = 1'b1;
        tick();

        run_op('0, '0, s, lat, bsy, ovr);
        chk("zero_latency", 64'(lat), 64'(NCH));
        chk("zero_busy_cycles", 64'(bsy), 64'(NCH));
        chk("zero_overrun", 64'(ovr), 64'(0));
        chk("zero_ready_in_done", 64'(bus_if.ready), 64'(1));
        chk_sum("zero_sum", s, '0);
        tick();
        chk("zero_done_pulse", 64'(bus_if.done), 64'(0));

        a = '1;
        b = W'(1);
        expv = '0;
        expv[W] = 1'b1;
        run_op(a, b, s, lat, bsy, ovr);
        chk("ripple_latency", 64'(lat), 64'(NCH));
        chk_sum("ripple_sum", s, expv);
        tick();

        for (int i = 0; i < 1000; i++) begin
            a = rand_w();
            case (i % 8)
                3:       b = ~a;
                7:       b = ~a + W'(1);
                default: b = rand_w();
            endcase
            run_op(a, b, s, lat, bsy, ovr);
            chk("rand_latency", 64'(lat), 64'(NCH));
            chk_sum("rand_sum", s, golden(a, b));
            if (i % 3 == 0) tick();
        end

        a  = rand_w();
        b  = rand_w();
        a2 = rand_w();
        b2 = rand_w();
        bus_if.r0 = a;
        bus_if.r1 = b;
        bus_if.en = 1'b1;
        tick();
        bus_if.en = 1'b0;
        bus_if.r0 = rand_w();
        bus_if.r1 = rand_w();
        for (int i = 0; i < 9; i++) tick();
        bus_if.r0 = a2;
        bus_if.r1 = b2;
        bus_if.en = 1'b1;
        tick();
        bus_if.en = 1'b0;
        chk("ovr_pulse", 64'(bus_if.overrun), 64'(1));
        tick();
        chk("ovr_clear", 64'(bus_if.overrun), 64'(0));
        wait_done(lat, bsy, ovr);
        chk("ovr_latency", 64'(lat + 11), 64'(NCH));
        chk_sum("ovr_sum", bus_if.sum, golden(a, b));
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            dcnt += int'(bus_if.done);
        end
        chk("ovr_single_done", 64'(dcnt), 64'(0));

        bus_if.r0 = rand_w();
        bus_if.r1 = rand_w();
        bus_if.en = 1'b1;
        tick();
        bus_if.en = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_busy", 64'(bus_if.busy), 64'(0));
        chk("rst_done", 64'(bus_if.done), 64'(0));
        chk("rst_ready", 64'(bus_if.ready), 64'(1));
        chk_sum("rst_sum", bus_if.sum, '0);
        a = rand_w();
        b = rand_w();
        run_op(a, b, s, lat, bsy, ovr);
        chk("rst_fresh_latency", 64'(lat), 64'(NCH));
        chk_sum("rst_fresh_sum", s, golden(a, b));
        tick();

        a  = rand_w();
        b  = rand_w();
        a2 = rand_w();
        b2 = ~a2;
        run_op(a, b, s, lat, bsy, ovr);
        chk("b2b_first_latency", 64'(lat), 64'(NCH));
        chk_sum("b2b_first_sum", s, golden(a, b));
        run_op(a2, b2, s2, lat, bsy, ovr);
        chk("b2b_second_latency", 64'(lat), 64'(NCH));
        chk("b2b_no_overrun", 64'(ovr), 64'(0));
        chk("b2b_busy_cycles", 64'(bsy), 64'(NCH));
        chk_sum("b2b_second_sum", s2, golden(a2, b2));
        tick();
        chk("b2b_idle_ready", 64'(bus_if.ready), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
